watch_keypad_clock: RTL and testbench
=====================================

Name: watch_keypad_clock

Overview:
Parametrised HH:MM:SS real-time clock with keypad time entry and a 6-digit multiplexed 7-segment driver.
- Time is always held internally as 24 h BCD. 12 h presentation is a display-only mode.
- Adds to the basic watch: input validation, cursor blink, edge-detected keys, and a clean run/set state machine.
- Sits between the keypad/button pins and the board's seg_data/seg_com lines.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per second; minimum 2.
SCAN_DIV, 1, clk cycles per display digit slot; minimum 1.
BLINK_TICKS, 250, clk cycles per blink half-period of the edited digit.
DEBOUNCE_CYCLES, 20, stable cycles required per key (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
key_input  in  10  keypad digits 0-9, one-hot, level
key_enter  in  1  '#' key, level; commits time and starts the clock
btn_set  in  1  level; returns the block to SET mode
mode_12h  in  1  1 = 12 h display, 0 = 24 h display
seg_data  out  8  segments, active-high; [7:1]=a..g, [0]=dp
seg_com  out  8  digit commons, active-low
set_mode  out  1  1 while in SET state
pm  out  1  1 when internal hour >= 12
sec_pulse  out  1  one-cycle strobe on each second increment

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=SET, cursor=0, time=00:00:00, tick=0, scan=0, blink phase=on.
  - Outputs: seg_data=8'h00, seg_com=8'hFF, set_mode=1, pm=0, sec_pulse=0.
  - Reset mid-operation aborts entry or counting with the same result.
- Key events:
  - key_input, key_enter and btn_set are registered once.
  - An event is a rising edge of the registered value (0 to 1).
  - Holding a key produces exactly one event.
  - key_input patterns that are not one-hot, including multi-key presses, are ignored.
- Priority on the same cycle: rst > btn_set > key_enter > digit.
- State SET:
  - Time is frozen, tick is held at 0, sec_pulse=0.
  - A digit event writes the position at the cursor only if it is valid:
    - h_ten must be <= 2.
    - h_one must be <= 9, or <= 3 when h_ten==2.
    - m_ten and s_ten must be <= 5.
    - m_one and s_one must be <= 9.
  - A valid write advances the cursor 0,1,2,3,4,5,0 (wraps).
  - An invalid digit: no write, no cursor move.
  - Writing h_ten=2 while h_one>3 also forces h_one=3 on the same edge.
  - key_enter event: go to RUN, tick=0. The first sec_pulse fires TICKS_PER_SEC cycles later.
- State RUN:
  - tick counts 0..TICKS_PER_SEC-1. At the terminal count: tick=0, sec_pulse=1 for one cycle, and s_one increments.
  - BCD cascade: s_one 9 to 0 carries into s_ten; s_ten 5 to 0 carries into m_one; m_one 9 carries; m_ten 5 carries into the hour.
  - h_one 9 to 0 increments h_ten.
  - 23:59:59 to 00:00:00 in a single edge.
  - btn_set event: go to SET, cursor=0, time is kept.
  - Digit and key_enter events are ignored in RUN.
- pm = (h_ten*10 + h_one) >= 12, registered with the time.
- Display:
  - scan advances every SCAN_DIV cycles through 0..5 and wraps; slots 6 and 7 are never used.
  - seg_com per slot:
    - 0 = 0111_1111
    - 1 = 1011_1111
    - 2 = 1101_1111
    - 3 = 1110_1111
    - 4 = 1111_0111
    - 5 = 1111_1011
  - seg_com and seg_data are registered: one cycle of latency after scan.
  - Digit patterns (a..g):
    - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
    - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - dp is lit on slots 1 and 3 (separators). dp on slot 5 = pm AND mode_12h.
  - 12 h mapping: hour 0 shows 12; hours 13-23 show hour-12; hour 12 shows 12. mode_12h changes take effect on the next displayed digit.
  - In SET, the slot equal to cursor shows seg_data=0 during the blink-off phase. The blink phase toggles every BLINK_TICKS cycles.
  - In RUN, nothing blinks.

Optional Feature:
Macro WATCH_KEY_DEBOUNCE_EN.
- Defined: each of the 12 key inputs passes a per-key counter. The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples. Edge detection runs on the filtered level, so total event latency = DEBOUNCE_CYCLES+2 cycles.
- Undefined: no filter. Event latency is 2 cycles (register plus edge detect), and DEBOUNCE_CYCLES is unused.

Test Plan:
1. Reset, then digits 1,2,3,4,5,6, then key_enter -> time 12:34:56, set_mode=0. After TICKS_PER_SEC cycles, one sec_pulse and time 12:34:57.
2. In SET at cursor 0, digit 3 -> rejected, cursor stays 0. Then digit 2 with h_one=7 -> h_ten=2 and h_one forced to 3.
3. Set 23:59:59 and run one second -> 00:00:00 on the same edge as sec_pulse, pm falls 1 to 0.
4. Key 5 held for 50 cycles in SET -> exactly one write. key_input=10'b0000100100 -> ignored.
5. mode_12h=1 with time 00:15:00 -> slots show 1,2,1,5,0,0, slot-5 dp=0. With time 13:00:00 -> 0,1,0,0,0,0, slot-5 dp=1.
6. rst asserted mid-entry (cursor=3) and mid-run -> next cycle seg_com=FF, seg_data=00, time 00:00:00, set_mode=1, cursor=0.

Source files
------------

// File: rtl/watch_keypad_clock_if.sv
// Pin bundle between keypad/buttons, the watch core and the board's 7-segment lines.
interface watch_keypad_clock_if;
   logic [9:0] key_input;
   logic       key_enter;
   logic       btn_set;
   logic       mode_12h;
   logic [7:0] seg_data;
   logic [7:0] seg_com;
   logic       set_mode;
   logic       pm;
   logic       sec_pulse;

   modport master (
      output key_input, key_enter, btn_set, mode_12h,
      input  seg_data, seg_com, set_mode, pm, sec_pulse
   );

   modport slave (
      input  key_input, key_enter, btn_set, mode_12h,
      output seg_data, seg_com, set_mode, pm, sec_pulse
   );
endinterface

// File: rtl/watch_keypad_clock.sv
// 24 h BCD HH:MM:SS clock with validated keypad entry and a 6-digit multiplexed display.
// Optional key debounce filter: define WATCH_KEY_DEBOUNCE_EN.
module watch_keypad_clock #(
   parameter int TICKS_PER_SEC   = 1000,
   parameter int SCAN_DIV        = 1,
   parameter int BLINK_TICKS     = 250,
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   watch_keypad_clock_if.slave  bus
);
   localparam int TW = $clog2(TICKS_PER_SEC);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);
   localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

   typedef enum logic {S_SET = 1'b0, S_RUN = 1'b1} state_t;

   state_t          r_state, w_state_nxt;
   logic            w_set_mode;
   logic [11:0]     r_key_q, r_key_prev, w_key_lvl, w_key_rise;
   logic            w_ev_btn, w_ev_ent, w_ev_dig, w_dig_ok;
   logic [3:0]      w_dig_val;
   logic [3:0]      r_dig [6];
   logic [3:0]      w_inc [6];
   logic [2:0]      r_cursor;
   logic [TW-1:0]   r_tick;
   logic            r_sec_pulse, w_tick_end;
   logic [SW-1:0]   r_scan_div;
   logic [2:0]      r_scan;
   logic [BW-1:0]   r_blink_cnt;
   logic            r_blink_on;
   logic [4:0]      w_hour, w_h12;
   logic            w_pm, w_dp, w_blank;
   logic [3:0]      w_disp_ht, w_disp_ho, w_slot_dig;
   logic [7:0]      r_seg_data, r_seg_com;

   function automatic logic [6:0] f_font(input logic [3:0] v);
      case (v)
         4'd0:    f_font = 7'b1111110;
         4'd1:    f_font = 7'b0110000;
         4'd2:    f_font = 7'b1101101;
         4'd3:    f_font = 7'b1111001;
         4'd4:    f_font = 7'b0110011;
         4'd5:    f_font = 7'b1011011;
         4'd6:    f_font = 7'b1011111;
         4'd7:    f_font = 7'b1110000;
         4'd8:    f_font = 7'b1111111;
         4'd9:    f_font = 7'b1111011;
         default: f_font = 7'b0000000;
      endcase
   endfunction

   function automatic logic [7:0] f_com(input logic [2:0] slot);
      case (slot)
         3'd0:    f_com = 8'b0111_1111;
         3'd1:    f_com = 8'b1011_1111;
         3'd2:    f_com = 8'b1101_1111;
         3'd3:    f_com = 8'b1110_1111;
         3'd4:    f_com = 8'b1111_0111;
         3'd5:    f_com = 8'b1111_1011;
         default: f_com = 8'b1111_1111;
      endcase
   endfunction

   // Key levels: {btn_set, key_enter, key_input[9:0]} registered once.
   always_ff @(posedge clk) begin
      if (rst) r_key_q <= '0;
      else     r_key_q <= {bus.btn_set, bus.key_enter, bus.key_input};
   end

`ifdef WATCH_KEY_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
   logic [11:0]   r_filt;
   logic [DW-1:0] r_db_cnt [12];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt <= '0;
         for (int i = 0; i < 12; i++) r_db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 12; i++) begin
            if (r_key_q[i] == r_filt[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_MAX) begin
               r_filt[i]   <= r_key_q[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end
   assign w_key_lvl = r_filt;
`else
   logic w_unused_dbc;
   assign w_unused_dbc = (DEBOUNCE_CYCLES > 0);
   assign w_key_lvl    = r_key_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_key_prev <= '0;
      else     r_key_prev <= w_key_lvl;
   end

   assign w_key_rise = w_key_lvl & ~r_key_prev;
   assign w_ev_btn   = w_key_rise[11];
   assign w_ev_ent   = w_key_rise[10];
   assign w_ev_dig   = $onehot(w_key_lvl[9:0]) && (w_key_rise[9:0] != 10'd0);

   always_comb begin
      w_dig_val = 4'd0;
      for (int i = 0; i < 10; i++)
         if (w_key_lvl[i]) w_dig_val = 4'(i);
   end

   always_comb begin
      case (r_cursor)
         3'd0:      w_dig_ok = (w_dig_val <= 4'd2);
         3'd1:      w_dig_ok = (r_dig[0] == 4'd2) ? (w_dig_val <= 4'd3) : (w_dig_val <= 4'd9);
         3'd2, 3'd4: w_dig_ok = (w_dig_val <= 4'd5);
         default:   w_dig_ok = (w_dig_val <= 4'd9);
      endcase
   end

   // Run/set FSM: state register, next state, outputs.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_SET;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_ev_btn)                            w_state_nxt = S_SET;
      else if (w_ev_ent && (r_state == S_SET)) w_state_nxt = S_RUN;
   end

   always_comb begin
      w_set_mode = (r_state == S_SET);
   end

   assign w_tick_end = (r_state == S_RUN) && (r_tick == TICK_MAX);

   always_comb begin
      w_inc = r_dig;
      if (r_dig[5] != 4'd9) w_inc[5] = r_dig[5] + 4'd1;
      else begin
         w_inc[5] = 4'd0;
         if (r_dig[4] != 4'd5) w_inc[4] = r_dig[4] + 4'd1;
         else begin
            w_inc[4] = 4'd0;
            if (r_dig[3] != 4'd9) w_inc[3] = r_dig[3] + 4'd1;
            else begin
               w_inc[3] = 4'd0;
               if (r_dig[2] != 4'd5) w_inc[2] = r_dig[2] + 4'd1;
               else begin
                  w_inc[2] = 4'd0;
                  if (r_dig[0] == 4'd2 && r_dig[1] == 4'd3) begin
                     w_inc[0] = 4'd0;
                     w_inc[1] = 4'd0;
                  end else if (r_dig[1] == 4'd9) begin
                     w_inc[0] = r_dig[0] + 4'd1;
                     w_inc[1] = 4'd0;
                  end else begin
                     w_inc[1] = r_dig[1] + 4'd1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dig       <= '{default: 4'd0};
         r_cursor    <= 3'd0;
         r_tick      <= '0;
         r_sec_pulse <= 1'b0;
      end else begin
         r_sec_pulse <= 1'b0;
         if (w_ev_btn) begin
            r_cursor <= 3'd0;
            r_tick   <= '0;
         end else if (r_state == S_SET) begin
            r_tick <= '0;
            if (!w_ev_ent && w_ev_dig && w_dig_ok) begin
               r_dig[r_cursor] <= w_dig_val;
               // Entering 2x hours clamps an already-typed ones digit into 20..23.
               if (r_cursor == 3'd0 && w_dig_val == 4'd2 && r_dig[1] > 4'd3) r_dig[1] <= 4'd3;
               r_cursor <= (r_cursor == 3'd5) ? 3'd0 : r_cursor + 3'd1;
            end
         end else if (w_tick_end) begin
            r_tick      <= '0;
            r_sec_pulse <= 1'b1;
            r_dig       <= w_inc;
         end else begin
            r_tick <= r_tick + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_div  <= '0;
         r_scan      <= 3'd0;
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else begin
         if (r_scan_div == SCAN_MAX) begin
            r_scan_div <= '0;
            r_scan     <= (r_scan == 3'd5) ? 3'd0 : r_scan + 3'd1;
         end else begin
            r_scan_div <= r_scan_div + 1'b1;
         end
         if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign w_hour = 5'(r_dig[0]) * 5'd10 + 5'(r_dig[1]);
   assign w_pm   = (w_hour >= 5'd12);

   // 12 h view is presentation only; the stored time stays 24 h.
   always_comb begin
      w_h12     = w_hour;
      w_disp_ht = r_dig[0];
      w_disp_ho = r_dig[1];
      if (bus.mode_12h) begin
         if (w_hour == 5'd0)       w_h12 = 5'd12;
         else if (w_hour > 5'd12)  w_h12 = w_hour - 5'd12;
         if (w_h12 >= 5'd10) begin
            w_disp_ht = 4'd1;
            w_disp_ho = 4'(w_h12 - 5'd10);
         end else begin
            w_disp_ht = 4'd0;
            w_disp_ho = 4'(w_h12);
         end
      end
   end

   always_comb begin
      case (r_scan)
         3'd0:    w_slot_dig = w_disp_ht;
         3'd1:    w_slot_dig = w_disp_ho;
         3'd2:    w_slot_dig = r_dig[2];
         3'd3:    w_slot_dig = r_dig[3];
         3'd4:    w_slot_dig = r_dig[4];
         3'd5:    w_slot_dig = r_dig[5];
         default: w_slot_dig = 4'd0;
      endcase
   end

   assign w_dp    = (r_scan == 3'd1) || (r_scan == 3'd3) ||
                    ((r_scan == 3'd5) && w_pm && bus.mode_12h);
   assign w_blank = (r_state == S_SET) && (r_scan == r_cursor) && !r_blink_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg_data <= 8'h00;
         r_seg_com  <= 8'hFF;
      end else begin
         r_seg_com  <= f_com(r_scan);
         r_seg_data <= w_blank ? 8'h00 : {f_font(w_slot_dig), w_dp};
      end
   end

   assign bus.seg_data  = r_seg_data;
   assign bus.seg_com   = r_seg_com;
   assign bus.set_mode  = w_set_mode;
   assign bus.pm        = w_pm;
   assign bus.sec_pulse = r_sec_pulse;
endmodule

// File: tb/tb_watch_keypad_clock.sv
// Randomized and directed bench for watch_keypad_clock against a seconds-of-day reference model.
module tb_watch_keypad_clock;
   localparam int T  = 40;
   localparam int SD = 2;
   localparam int BT = 7;

   logic clk, rst;
   watch_keypad_clock_if bus_if();

   watch_keypad_clock #(
      .TICKS_PER_SEC(T), .SCAN_DIV(SD), .BLINK_TICKS(BT), .DEBOUNCE_CYCLES(3)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks, n_fail, cyc_n;
   logic [6:0]  font [10];
   logic [7:0]  com_tab [6];
   int          m_dig [6];
   int          m_cur, m_run, m_c;
   bit          m_set, m_pulse;
   logic [7:0]  m_sd, m_sc;
   logic [11:0] k_q, k_p;
   logic [23:0] rd_bcd;
   logic [5:0]  rd_dp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   function automatic int hour_now();
      return m_dig[0] * 10 + m_dig[1];
   endfunction

   function automatic bit digit_ok(int pos, int v);
      case (pos)
         0:       return v <= 2;
         1:       return (m_dig[0] == 2) ? (v <= 3) : (v <= 9);
         2, 4:    return v <= 5;
         default: return 1'b1;
      endcase
   endfunction

   // Reference: one call per clock edge, reading the inputs the DUT sampled on that edge.
   task automatic model_edge();
      int slot, h, v, secs;
      int shown [6];
      bit blink_on, pm_pre, ev_b, ev_e, ev_d;
      logic [11:0] rise;
      if (rst) begin
         m_set = 1; m_cur = 0; m_run = 0; m_pulse = 0; m_c = 0;
         for (int i = 0; i < 6; i++) m_dig[i] = 0;
         m_sd = 8'h00; m_sc = 8'hFF; k_q = '0; k_p = '0;
      end else begin
         slot     = (m_c / SD) % 6;
         blink_on = ((m_c / BT) % 2) == 0;
         h        = hour_now();
         pm_pre   = (h >= 12);
         if (bus_if.mode_12h) h = (h % 12 == 0) ? 12 : h % 12;
         shown[0] = h / 10; shown[1] = h % 10;
         for (int i = 2; i < 6; i++) shown[i] = m_dig[i];
         m_sc = com_tab[slot];
         if (m_set && slot == m_cur && !blink_on) m_sd = 8'h00;
         else m_sd = {font[shown[slot]], (slot == 1 || slot == 3 || (slot == 5 && pm_pre && bus_if.mode_12h))};

         rise = k_q & ~k_p;
         ev_b = rise[11];
         ev_e = rise[10];
         ev_d = $onehot(k_q[9:0]) && (rise[9:0] != 0);
         v = 0;
         for (int i = 0; i < 10; i++) if (k_q[i]) v = i;
         m_pulse = 0;
         if (ev_b) begin
            m_set = 1; m_cur = 0;
         end else if (m_set) begin
            if (ev_e) begin
               m_set = 0; m_run = 0;
            end else if (ev_d && digit_ok(m_cur, v)) begin
               m_dig[m_cur] = v;
               if (m_cur == 0 && v == 2 && m_dig[1] > 3) m_dig[1] = 3;
               m_cur = (m_cur + 1) % 6;
            end
         end else begin
            m_run++;
            if (m_run % T == 0) begin
               secs = (hour_now() * 60 + m_dig[2] * 10 + m_dig[3]) * 60 + m_dig[4] * 10 + m_dig[5];
               secs = (secs + 1) % 86400;
               m_dig[0] = (secs / 3600) / 10; m_dig[1] = (secs / 3600) % 10;
               m_dig[2] = ((secs / 60) % 60) / 10; m_dig[3] = ((secs / 60) % 60) % 10;
               m_dig[4] = (secs % 60) / 10; m_dig[5] = (secs % 60) % 10;
               m_pulse = 1;
            end
         end
         k_p = k_q;
         k_q = {bus_if.btn_set, bus_if.key_enter, bus_if.key_input};
         m_c++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc_n++;
      check("outs", {13'd0, bus_if.seg_data, bus_if.seg_com, bus_if.set_mode, bus_if.pm, bus_if.sec_pulse},
                    {13'd0, m_sd, m_sc, m_set, (hour_now() >= 12), m_pulse});
   endtask

   task automatic press_digit(input int d);
      bus_if.key_input = 10'(32'd1 << d);
      step(); step();
      bus_if.key_input = '0;
      step(); step();
   endtask

   task automatic press_enter();
      bus_if.key_enter = 1'b1; step(); step();
      bus_if.key_enter = 1'b0; step(); step();
   endtask

   task automatic press_btn();
      bus_if.btn_set = 1'b1; step(); step();
      bus_if.btn_set = 1'b0; step(); step();
   endtask

   task automatic type6(input int a, input int b, input int c, input int d, input int e, input int f);
      press_digit(a); press_digit(b); press_digit(c);
      press_digit(d); press_digit(e); press_digit(f);
   endtask

   function automatic logic [3:0] dig_of(input logic [6:0] seg);
      for (int i = 0; i < 10; i++) if (font[i] == seg) return 4'(i);
      return 4'hF;
   endfunction

   task automatic read_disp();
      rd_bcd = '1;
      rd_dp  = '0;
      for (int n = 0; n < 6 * SD + 2; n++) begin
         step();
         for (int s = 0; s < 6; s++)
            if (bus_if.seg_com == com_tab[s]) begin
               rd_bcd[23 - 4 * s -: 4] = dig_of(bus_if.seg_data[7:1]);
               rd_dp[s] = bus_if.seg_data[0];
            end
      end
   endtask

   task automatic wait_pulse();
      int n;
      n = 0;
      while (!bus_if.sec_pulse && n < 4 * T) begin
         step();
         n++;
      end
      check("pulse_seen", 32'(bus_if.sec_pulse), 32'd1);
   endtask

   initial begin
      int t0, r;
      n_checks = 0; n_fail = 0; cyc_n = 0;
      font    = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
      com_tab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB};
      rst = 1'b1;
      bus_if.key_input = '0; bus_if.key_enter = 1'b0;
      bus_if.btn_set   = 1'b0; bus_if.mode_12h = 1'b0;
      step(); step();
      check("rst_com", 32'(bus_if.seg_com), 32'hFF);
      check("rst_data", 32'(bus_if.seg_data), 32'h00);
      check("rst_set_mode", 32'(bus_if.set_mode), 32'd1);
      check("rst_pm_pulse", {30'd0, bus_if.pm, bus_if.sec_pulse}, 32'd0);
      rst = 1'b0;

      // Entry 12:34:56, then the first second.
      type6(1, 2, 3, 4, 5, 6);
      t0 = cyc_n;
      bus_if.key_enter = 1'b1; step(); step();
      bus_if.key_enter = 1'b0;
      read_disp();
      check("t1_disp", 32'(rd_bcd), 32'h123456);
      check("t1_set_mode", 32'(bus_if.set_mode), 32'd0);
      wait_pulse();
      check("t1_pulse_dly", 32'(cyc_n - t0), 32'(T + 2));
      read_disp();
      check("t1_disp_next", 32'(rd_bcd), 32'h123457);

      // Validation and h_one clamp.
      press_btn();
      type6(1, 7, 0, 0, 0, 0);
      press_digit(3);
      press_digit(2);
      press_enter();
      read_disp();
      check("t2_disp", 32'(rd_bcd), 32'h230000);

      // Midnight rollover.
      press_btn();
      type6(2, 3, 5, 9, 5, 9);
      press_enter();
      read_disp();
      check("t3_disp", 32'(rd_bcd), 32'h235959);
      check("t3_pm_before", 32'(bus_if.pm), 32'd1);
      wait_pulse();
      check("t3_pm_after", 32'(bus_if.pm), 32'd0);
      read_disp();
      check("t3_disp_wrap", 32'(rd_bcd), 32'h000000);

      // Held key gives one write; multi-key press is ignored.
      press_btn();
      press_digit(1);
      bus_if.key_input = 10'(32'd1 << 5);
      for (int i = 0; i < 50; i++) step();
      bus_if.key_input = '0; step(); step();
      bus_if.key_input = 10'b0000100100;
      for (int i = 0; i < 4; i++) step();
      bus_if.key_input = '0; step(); step();
      press_digit(3); press_digit(0); press_digit(0); press_digit(0);
      press_enter();
      read_disp();
      check("t4_disp", 32'(rd_bcd), 32'h153000);

      // 12 h presentation.
      bus_if.mode_12h = 1'b1;
      press_btn();
      type6(0, 0, 1, 5, 0, 0);
      press_enter();
      read_disp();
      check("t5_disp_midnight", 32'(rd_bcd), 32'h121500);
      check("t5_dp_am", 32'(rd_dp), 32'b001010);
      press_btn();
      type6(1, 3, 0, 0, 0, 0);
      press_enter();
      read_disp();
      check("t5_disp_pm", 32'(rd_bcd), 32'h010000);
      check("t5_dp_pm", 32'(rd_dp), 32'b101010);
      bus_if.mode_12h = 1'b0;

      // Reset mid-entry and mid-run.
      press_btn();
      press_digit(1); press_digit(2); press_digit(3);
      rst = 1'b1; step(); rst = 1'b0;
      check("t6a_com", 32'(bus_if.seg_com), 32'hFF);
      check("t6a_data", 32'(bus_if.seg_data), 32'h00);
      check("t6a_set_mode", 32'(bus_if.set_mode), 32'd1);
      for (int i = 0; i < 20; i++) step();
      press_digit(1); press_digit(9);
      press_enter();
      for (int i = 0; i < 60; i++) step();
      rst = 1'b1; step(); rst = 1'b0;
      check("t6b_com", 32'(bus_if.seg_com), 32'hFF);
      check("t6b_data", 32'(bus_if.seg_data), 32'h00);
      check("t6b_set_mode", 32'(bus_if.set_mode), 32'd1);
      press_enter();
      read_disp();
      check("t6b_disp", 32'(rd_bcd), 32'h000000);

      // Random stimulus, every cycle compared to the model.
      for (int n = 0; n < 4000; n++) begin
         rst = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 10)       bus_if.key_input = 10'(32'd1 << $urandom_range(0, 9));
         else if (r < 22)  bus_if.key_input = '0;
         else if (r < 24)  bus_if.key_input = 10'($urandom);
         else if (r < 27)  bus_if.key_enter = ~bus_if.key_enter;
         else if (r == 27) bus_if.btn_set = ~bus_if.btn_set;
         else if (r == 28) bus_if.mode_12h = ~bus_if.mode_12h;
         else if (r == 29 && $urandom_range(0, 9) == 0) rst = 1'b1;
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
